// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W   = 64;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned BE_W     = 8;
   localparam int unsigned STREAK_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_RSP
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_D
   } arb_owner_t;

   // Saturating increment of the data streak counter.
   function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur,
                                                      input logic [STREAK_W-1:0] max_val);
      if (cur >= max_val) begin
         return max_val;
      end
      return cur + STREAK_W'(1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and the LSU.
// One transaction in flight; data has priority, bounded by a streak counter
// so a pending fetch is always served after MAX_D_STREAK data grants.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,

   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [BE_W-1:0]   d_be_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [BE_W-1:0]   mem_be_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_D_STREAK);

   arb_state_t            state_q, state_d;
   arb_owner_t            owner_q, owner_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;

   logic                  fetch_wins;
   arb_owner_t            eff_owner;
   logic                  issuing;
   logic                  granted;

   // Pick the port driving the memory this cycle: fresh arbitration in IDLE,
   // latched owner otherwise. Outputs are forced quiet while reset is held.
   always_comb begin
      fetch_wins = if_req_i && (!d_req_i || (streak_q == MaxStreak));
      eff_owner  = owner_q;
      if (state_q == ARB_IDLE) begin
         if (fetch_wins) begin
            eff_owner = OWN_IF;
         end else if (d_req_i) begin
            eff_owner = OWN_D;
         end else begin
            eff_owner = OWN_NONE;
         end
      end
      issuing = rst_ni && (state_q != ARB_RSP) && (eff_owner != OWN_NONE);
      granted = issuing && mem_gnt_i;
   end

   // Drive the memory request from the effective owner; unused fields stay 0.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (issuing) begin
         mem_req_o = 1'b1;
         unique case (eff_owner)
            OWN_IF: begin
               // Fetch reads the full doubleword; be stays 0.
               mem_addr_o = if_addr_i;
            end
            OWN_D: begin
               mem_we_o    = d_we_i;
               mem_addr_o  = d_addr_i;
               mem_wdata_o = d_wdata_i;
               mem_be_o    = d_be_i;
            end
            default: begin
               mem_req_o = 1'b0;
            end
         endcase
      end
   end

   // Route the memory grant to the owning port only.
   always_comb begin
      if_gnt_o = granted && (eff_owner == OWN_IF);
      d_gnt_o  = granted && (eff_owner == OWN_D);
   end

   // Forward the response only while waiting for it; rdata is 0 otherwise.
   always_comb begin
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      d_rvalid_o  = 1'b0;
      d_rdata_o   = '0;
      if (rst_ni && (state_q == ARB_RSP) && mem_rvalid_i) begin
         unique case (owner_q)
            OWN_IF: begin
               if_rvalid_o = 1'b1;
               if_rdata_o  = mem_rdata_i;
            end
            OWN_D: begin
               d_rvalid_o = 1'b1;
               d_rdata_o  = mem_rdata_i;
            end
            default: begin
               if_rvalid_o = 1'b0;
            end
         endcase
      end
   end

   // Next-state logic for the transaction FSM, owner latch and streak counter.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      streak_d = streak_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (issuing) begin
               owner_d = eff_owner;
               state_d = mem_gnt_i ? ARB_RSP : ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (mem_gnt_i) begin
               state_d = ARB_RSP;
            end
         end
         ARB_RSP: begin
            if (mem_rvalid_i) begin
               state_d = ARB_IDLE;
               owner_d = OWN_NONE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
         end
      endcase

      // Only count data grants that made a pending fetch wait.
      if (granted) begin
         if ((eff_owner == OWN_D) && if_req_i) begin
            streak_d = streak_inc(streak_q, MaxStreak);
         end else begin
            streak_d = '0;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_NONE;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(if_gnt_o && d_gnt_o));

   a_rvalid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(if_rvalid_o && d_rvalid_o));

   a_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == ARB_REQ) |-> mem_req_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int unsigned MaxD = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        if_req_i;
   logic [63:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [63:0] if_rdata_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [63:0] d_addr_i;
   logic [63:0] d_wdata_i;
   logic [7:0]  d_be_i;
   logic        d_gnt_o;
   logic        d_rvalid_o;
   logic [63:0] d_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_be_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [63:0] mem_rdata_i;

   mem_port_arbiter #(.MAX_D_STREAK(MaxD)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_gnt_o     (if_gnt_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_rdata_o   (if_rdata_o),
      .d_req_i      (d_req_i),
      .d_we_i       (d_we_i),
      .d_addr_i     (d_addr_i),
      .d_wdata_i    (d_wdata_i),
      .d_be_i       (d_be_i),
      .d_gnt_o      (d_gnt_o),
      .d_rvalid_o   (d_rvalid_o),
      .d_rdata_o    (d_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: who holds the port, whether memory accepted it,
   // and how many data grants a waiting fetch has sat through.
   int m_owner   = 0;  // 0 none, 1 fetch, 2 data
   bit m_granted = 1'b0;
   int m_streak  = 0;

   bit log_en = 1'b0;
   bit gq[$];

   int          cur;
   bit          iss;
   bit          resp;
   logic        e_mem_req, e_mem_we, e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;
   logic [63:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
   logic [7:0]  e_mem_be;

   // Compare every output against the model once per cycle.
   initial begin
      forever begin
         @(negedge clk_i);
         e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_be = 0;
         e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_if_rdata = 0; e_d_rdata = 0;
         iss = 0; resp = 0; cur = 0;
         if (rst_ni) begin
            if (m_owner == 0) begin
               if (if_req_i && (!d_req_i || m_streak == MaxD)) cur = 1;
               else if (d_req_i) cur = 2;
            end else begin
               cur = m_owner;
            end
            iss  = (cur != 0) && !m_granted;
            resp = m_granted && mem_rvalid_i;
            if (iss) begin
               e_mem_req  = 1;
               e_mem_addr = (cur == 1) ? if_addr_i : d_addr_i;
               if (cur == 2) begin
                  e_mem_we = d_we_i; e_mem_wdata = d_wdata_i; e_mem_be = d_be_i;
               end
               e_if_gnt = (cur == 1) && mem_gnt_i;
               e_d_gnt  = (cur == 2) && mem_gnt_i;
            end
            if (resp) begin
               e_if_rv = (m_owner == 1); e_d_rv = (m_owner == 2);
               e_if_rdata = e_if_rv ? mem_rdata_i : 64'h0;
               e_d_rdata  = e_d_rv  ? mem_rdata_i : 64'h0;
            end
         end
         chk("if_gnt", if_gnt_o, e_if_gnt);
         chk("d_gnt", d_gnt_o, e_d_gnt);
         chk("if_rvalid", if_rvalid_o, e_if_rv);
         chk("if_rdata", if_rdata_o, e_if_rdata);
         chk("d_rvalid", d_rvalid_o, e_d_rv);
         chk("d_rdata", d_rdata_o, e_d_rdata);
         chk("mem_req", mem_req_o, e_mem_req);
         chk("mem_we", mem_we_o, e_mem_we);
         chk("mem_addr", mem_addr_o, e_mem_addr);
         chk("mem_wdata", mem_wdata_o, e_mem_wdata);
         chk("mem_be", {56'h0, mem_be_o}, {56'h0, e_mem_be});
         if (log_en && if_gnt_o) gq.push_back(1'b1);
         else if (log_en && d_gnt_o) gq.push_back(1'b0);
         // Advance the model to the state after the coming rising edge.
         if (!rst_ni) begin
            m_owner = 0; m_granted = 0; m_streak = 0;
         end else if (resp) begin
            m_owner = 0; m_granted = 0;
         end else if (iss) begin
            m_owner = cur;
            if (mem_gnt_i) begin
               m_granted = 1;
               if (cur == 1 || !if_req_i) m_streak = 0;
               else m_streak = (m_streak + 1 > MaxD) ? MaxD : m_streak + 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic quiet();
      if_req_i = 0; d_req_i = 0; d_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
   endtask

   logic [9:0]  order_pat;
   bit          got_if, got_d, acc, pend;
   int          dly;

   initial begin
      rst_ni = 0;
      if_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; d_be_i = 0; mem_rdata_i = 0;
      quiet();
      // Requests and gnt during reset must not reach any output.
      if_req_i = 1; d_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
      @(negedge clk_i);
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_if_gnt", if_gnt_o, 0);
      chk("rst_d_rvalid", d_rvalid_o, 0);
      step();
      rst_ni = 1; quiet();
      step();

      // Single fetch with zero-latency grant.
      if_req_i = 1; if_addr_i = 64'h1000; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("fetch_gnt", if_gnt_o, 1);
      chk("fetch_addr", mem_addr_o, 64'h1000);
      chk("fetch_be", {56'h0, mem_be_o}, 64'h0);
      step();
      if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'hDEADBEEF_00000013;
      @(negedge clk_i);
      chk("fetch_rvalid", if_rvalid_o, 1);
      chk("fetch_rdata", if_rdata_o, 64'hDEADBEEF_00000013);
      step();
      mem_rvalid_i = 0;
      @(negedge clk_i);
      chk("fetch_rvalid_pulse", if_rvalid_o, 0);
      step();

      // Store stalled three cycles on gnt.
      d_req_i = 1; d_we_i = 1; d_addr_i = 64'h2004; d_wdata_i = 64'h11223344_00000000;
      d_be_i = 8'hF0;
      for (int k = 0; k < 4; k++) begin
         mem_gnt_i = (k == 3);
         @(negedge clk_i);
         chk("stall_req", mem_req_o, 1);
         chk("stall_addr", mem_addr_o, 64'h2004);
         chk("stall_be", {56'h0, mem_be_o}, 64'hF0);
         chk("stall_gnt", d_gnt_o, (k == 3));
         step();
      end
      d_req_i = 0; d_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'hABCD;
      @(negedge clk_i);
      chk("store_rvalid", d_rvalid_o, 1);
      chk("store_rdata", d_rdata_o, 64'hABCD);
      step();
      mem_rvalid_i = 0;

      // Contention: both requesters always pending, memory immediate.
      if_addr_i = 64'h3000; d_addr_i = 64'h4000; d_be_i = 8'hFF;
      if_req_i = 1; d_req_i = 1; log_en = 1;
      for (int k = 0; k < 20; k++) begin
         mem_gnt_i = 1; mem_rvalid_i = 0;
         step();
         mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'(k);
         step();
      end
      log_en = 0; quiet();
      chk("contention_grants", 64'(gq.size()), 64'd20);
      order_pat = 10'b10_0001_0000;  // bit i set = fetch wins grant i
      for (int i = 0; i < 10; i++) begin
         if (i < gq.size()) chk($sformatf("order_%0d", i), 64'(gq[i]), 64'(order_pat[i]));
         else chk($sformatf("order_%0d", i), 64'h0, 64'h1);
      end
      step();

      // Owner lock: a later data request cannot steal a latched fetch.
      if_req_i = 1; if_addr_i = 64'h5000;
      @(negedge clk_i);
      chk("lock_addr0", mem_addr_o, 64'h5000);
      step();
      d_req_i = 1; d_we_i = 0; d_addr_i = 64'h6000;
      @(negedge clk_i);
      chk("lock_addr1", mem_addr_o, 64'h5000);
      chk("lock_dgnt1", d_gnt_o, 0);
      step();
      mem_gnt_i = 1;
      @(negedge clk_i);
      chk("lock_ifgnt", if_gnt_o, 1);
      chk("lock_dgnt2", d_gnt_o, 0);
      step();
      if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h77;
      @(negedge clk_i);
      chk("lock_ifrv", if_rvalid_o, 1);
      chk("lock_dgnt3", d_gnt_o, 0);
      step();
      mem_rvalid_i = 0; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("lock_dgnt4", d_gnt_o, 1);
      chk("lock_daddr", mem_addr_o, 64'h6000);
      step();
      d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h88;
      @(negedge clk_i);
      chk("lock_drv", d_rvalid_o, 1);
      step();
      quiet();

      // Spurious rvalid in IDLE is dropped.
      mem_rvalid_i = 1; mem_rdata_i = 64'h55;
      @(negedge clk_i);
      chk("spur_ifrv", if_rvalid_o, 0);
      chk("spur_drv", d_rvalid_o, 0);
      chk("spur_rdata", if_rdata_o, 0);
      step();
      mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 64'h5100; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("spur_idle_gnt", if_gnt_o, 1);
      step();
      if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      step();
      quiet();

      // Reset while waiting for a response.
      if_req_i = 1; if_addr_i = 64'h7000; mem_gnt_i = 1;
      step();
      mem_gnt_i = 0; d_req_i = 1;
      step();
      rst_ni = 0;
      #1;
      chk("rstmid_req", mem_req_o, 0);
      chk("rstmid_addr", mem_addr_o, 0);
      @(negedge clk_i);
      chk("rstmid_ifgnt", if_gnt_o, 0);
      step();
      rst_ni = 1; quiet();
      if_req_i = 1; if_addr_i = 64'h8000; mem_gnt_i = 1; mem_rvalid_i = 1;
      mem_rdata_i = 64'hBAD;
      @(negedge clk_i);
      chk("rstmid_stale", if_rvalid_o, 0);
      chk("rstmid_newgnt", if_gnt_o, 1);
      step();
      if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h600D;
      @(negedge clk_i);
      chk("rstmid_newrv", if_rdata_o, 64'h600D);
      step();
      quiet();
      step();

      // Randomized traffic with a memory that answers 1..4 cycles after gnt.
      pend = 0; dly = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk_i);
         got_if = if_gnt_o; got_d = d_gnt_o; acc = mem_req_o && mem_gnt_i;
         @(posedge clk_i);
         #1;
         if (!if_req_i || got_if) begin
            if_req_i  = ($urandom_range(0, 9) < 6);
            if_addr_i = {$urandom, $urandom} & ~64'h3;
         end
         if (!d_req_i || got_d) begin
            d_req_i   = ($urandom_range(0, 9) < 6);
            d_we_i    = $urandom_range(0, 1) == 1;
            d_addr_i  = {$urandom, $urandom};
            d_wdata_i = {$urandom, $urandom};
            d_be_i    = 8'($urandom);
         end
         mem_gnt_i = $urandom_range(0, 1) == 1;
         if (acc) begin
            pend = 1; dly = $urandom_range(0, 3);
         end
         mem_rdata_i = {$urandom, $urandom};
         if (pend) begin
            if (dly == 0) begin
               mem_rvalid_i = 1; pend = 0;
            end else begin
               mem_rvalid_i = 0; dly--;
            end
         end else begin
            mem_rvalid_i = ($urandom_range(0, 7) == 0);
         end
      end
      quiet();
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
